// File: rtl/sram_wb_march_pkg.sv
// rtl/sram_wb_march_pkg.sv - shared types and helpers for the SRAM march tester
// Purpose : march FSM state encoding, Wishbone select constant, pattern function.
// Ports   : none (package).
// Config  : none.
package sram_wb_march_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W0,
    ST_R0,
    ST_W1,
    ST_R1,
    ST_DONE
  } state_e;

  localparam logic [3:0] SEL_ALL = 4'hF;

  // Pattern for word address a; the caller zero-extends a to 32 bits.
  function automatic logic [31:0] pattern_d(input logic [31:0] seed, input logic [31:0] word_addr);
    return seed ^ word_addr;
  endfunction

endpackage

// File: rtl/sram_wb_march_tester_if.sv
// rtl/sram_wb_march_tester_if.sv - Wishbone classic bus between march tester and SRAM slave
// Purpose : groups the Wishbone classic signals of one initiator/target pair.
// Signals : cyc, stb, we, sel[3:0], adr[31:0], dat_m2s[31:0] (initiator -> target);
//           dat_s2m[31:0], ack (target -> initiator).
// Modports: master (the tester), slave (the SRAM or a model of it).
// Config  : none.
interface sram_wb_march_tester_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_m2s;
  logic [31:0] dat_s2m;
  logic        ack;

  modport master (output cyc, stb, we, sel, adr, dat_m2s, input dat_s2m, ack);
  modport slave  (input cyc, stb, we, sel, adr, dat_m2s, output dat_s2m, ack);
endinterface

// File: rtl/sram_wb_single_xfer.sv
// rtl/sram_wb_single_xfer.sv - single outstanding Wishbone classic transaction engine
// Purpose : launches one transaction per accepted request and holds the bus stable until ack.
// Ports   : clk_i, rst_ni (async active-low); req_i, we_i, adr_i[31:0], wdat_i[31:0] request;
//           done_o (pulse in the ack cycle), rdat_o[31:0] (valid with done_o),
//           timeout_o (pulse when the watchdog expires); wbm (Wishbone master modport).
// Config  : SRAM_WB_TESTER_TIMEOUT_EN enables the ack watchdog (TIMEOUT cycles).
module sram_wb_single_xfer
  import sram_wb_march_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          req_i,
  input  logic                          we_i,
  input  logic [31:0]                   adr_i,
  input  logic [31:0]                   wdat_i,
  output logic                          done_o,
  output logic [31:0]                   rdat_o,
  output logic                          timeout_o,
  sram_wb_march_tester_if.master        wbm
);

  logic        stb_q, stb_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic        ack_hit;
  logic        expire;

  // ack is only meaningful while our strobe is up.
  assign ack_hit = stb_q & wbm.ack;

`ifdef SRAM_WB_TESTER_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_q, wd_d;

  // Expires on the TIMEOUT-th consecutive cycle of stb without ack.
  assign expire = stb_q & ~wbm.ack & (wd_q == WDW'(TIMEOUT - 1));

  always_comb begin
    wd_d = '0;
    if (stb_q && !wbm.ack && !expire) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wd_q <= '0;
    else         wd_q <= wd_d;
  end
`else
  // Watchdog compiled out: the engine waits for ack indefinitely.
  assign expire = 1'b0 & (TIMEOUT != 0);
`endif

  // A new request is only taken while idle, so the cycle after an ack
  // always has cyc/stb low before the next strobe.
  always_comb begin
    stb_d = stb_q;
    we_d  = we_q;
    adr_d = adr_q;
    dat_d = dat_q;
    if (!stb_q) begin
      if (req_i) begin
        stb_d = 1'b1;
        we_d  = we_i;
        adr_d = adr_i;
        dat_d = wdat_i;
      end
    end else if (ack_hit || expire) begin
      stb_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stb_q <= 1'b0;
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else begin
      stb_q <= stb_d;
      we_q  <= we_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
    end
  end

  assign wbm.cyc     = stb_q;
  assign wbm.stb     = stb_q;
  assign wbm.we      = we_q;
  assign wbm.sel     = stb_q ? SEL_ALL : 4'h0;
  assign wbm.adr     = adr_q;
  assign wbm.dat_m2s = dat_q;

  assign done_o    = ack_hit;
  assign rdat_o    = wbm.dat_s2m;
  assign timeout_o = expire;

endmodule

// File: rtl/sram_wb_march_tester.sv
// rtl/sram_wb_march_tester.sv - Wishbone march-test initiator for the 1024x32 SRAM
// Purpose : runs W0 (up, D), R0/W1 (up, read D then write ~D), R1 (down, read ~D)
//           with D(a) = seed ^ a, and reports pass/fail and miscompare statistics.
// Ports   : wb_clk_i, wb_rst_ni (async active-low); start_i, seed_i[31:0] control;
//           busy_o, done_o, pass_o, err_count_o[AW+1:0], first_err_addr_o[AW-1:0],
//           timeout_o status; wbm (Wishbone master modport).
// Config  : SRAM_WB_TESTER_TIMEOUT_EN enables the ack watchdog; otherwise timeout_o is 0.
module sram_wb_march_tester
  import sram_wb_march_pkg::*;
#(
  parameter int          AW        = 10,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_ni,
  input  logic                   start_i,
  input  logic [31:0]            seed_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic [AW+1:0]          err_count_o,
  output logic [AW-1:0]          first_err_addr_o,
  output logic                   timeout_o,
  sram_wb_march_tester_if.master wbm
);

  localparam logic [AW-1:0] ADDR_MAX = '1;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   seed_q, seed_d;
  logic [AW+1:0] err_q, err_d;
  logic [AW-1:0] first_q, first_d;
  logic          to_q, to_d;

  logic          x_req, x_we, x_done, x_to;
  logic [31:0]   x_adr, x_wdat, x_rdat;
  logic [31:0]   exp_d;
  logic          miscompare;

  assign exp_d  = pattern_d(seed_q, 32'(addr_q));
  assign x_req  = (state_q == ST_W0) || (state_q == ST_R0) ||
                  (state_q == ST_W1) || (state_q == ST_R1);
  assign x_we   = (state_q == ST_W0) || (state_q == ST_W1);
  assign x_wdat = (state_q == ST_W0) ? exp_d : ~exp_d;
  assign x_adr  = BASE_ADDR + (32'(addr_q) << 2);

  assign miscompare = x_done &&
                      (((state_q == ST_R0) && (x_rdat != exp_d)) ||
                       ((state_q == ST_R1) && (x_rdat != ~exp_d)));

  sram_wb_single_xfer #(.TIMEOUT(TIMEOUT)) u_xfer (
    .clk_i     (wb_clk_i),
    .rst_ni    (wb_rst_ni),
    .req_i     (x_req),
    .we_i      (x_we),
    .adr_i     (x_adr),
    .wdat_i    (x_wdat),
    .done_o    (x_done),
    .rdat_o    (x_rdat),
    .timeout_o (x_to),
    .wbm       (wbm)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    err_d   = err_q;
    first_d = first_q;
    to_d    = to_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d = ST_W0;
          addr_d  = '0;
          seed_d  = seed_i;
          err_d   = '0;
          first_d = '0;
          to_d    = 1'b0;
        end
      end
      ST_W0: begin
        if (x_done) begin
          if (addr_q == ADDR_MAX) begin
            state_d = ST_R0;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_R0: if (x_done) state_d = ST_W1;
      ST_W1: begin
        // R1 starts at the top address, which is where the last W1 left addr_q.
        if (x_done) begin
          if (addr_q == ADDR_MAX) begin
            state_d = ST_R1;
          end else begin
            state_d = ST_R0;
            addr_d  = addr_q + 1'b1;
          end
        end
      end
      ST_R1: begin
        if (x_done) begin
          if (addr_q == '0) state_d = ST_DONE;
          else              addr_d  = addr_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (miscompare) begin
      if (err_q == '0) first_d = addr_q;
      if (err_q != '1) err_d   = err_q + 1'b1;
    end

    if (x_to) begin
      state_d = ST_DONE;
      to_d    = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
      err_q   <= err_d;
      first_q <= first_d;
      to_q    <= to_d;
    end
  end

  assign busy_o           = x_req;
  assign done_o           = (state_q == ST_DONE);
  assign pass_o           = done_o && (err_q == '0) && !to_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;
  assign timeout_o        = to_q;

endmodule

// File: tb/tb_sram_wb_march_tester.sv
// tb/tb_sram_wb_march_tester.sv - directed self-checking bench for sram_wb_march_tester
module tb_sram_wb_march_tester;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          TMO  = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] seed = '0;
  logic        busy, done, pass, tmo;
  logic [11:0] err_cnt;
  logic [9:0]  first_err;

  int errors = 0;
  int checks = 0;

  sram_wb_march_tester_if bus ();

  sram_wb_march_tester dut (
    .wb_clk_i         (clk),
    .wb_rst_ni        (rst_n),
    .start_i          (start),
    .seed_i           (seed),
    .busy_o           (busy),
    .done_o           (done),
    .pass_o           (pass),
    .err_count_o      (err_cnt),
    .first_err_addr_o (first_err),
    .timeout_o        (tmo),
    .wbm              (bus)
  );

  always #5 clk = ~clk;

  // Ideal SRAM model: ack combinational on stb (latency 1), optional stuck-at and no-ack faults.
  logic [31:0] mem [0:1023];
  logic [9:0]  idx;
  logic        stuck_en = 1'b0;
  logic        noack_en = 1'b0;
  logic [31:0] rd_raw;
  int          acks = 0;
  int          writes = 0;
  logic        w0_seen = 1'b0;
  logic [31:0] w0_dat = '0;

  assign idx         = bus.adr[11:2];
  assign rd_raw      = mem[idx];
  assign bus.dat_s2m = (stuck_en && idx == 10'h155) ? (rd_raw & ~32'h80) : rd_raw;
  assign bus.ack     = bus.stb && !(noack_en && idx == 10'h010);

  always @(posedge clk) begin
    if (bus.cyc && bus.stb && bus.ack) begin
      acks = acks + 1;
      if (bus.we) begin
        writes = writes + 1;
        mem[idx] = bus.dat_m2s;
        if (idx == 10'h0 && !w0_seen) begin
          w0_seen = 1'b1;
          w0_dat  = bus.dat_m2s;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    acks = 0;
    writes = 0;
    w0_seen = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] s);
    @(negedge clk);
    seed  = s;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy_cycles);
    int n = 0;
    busy_cycles = 0;
    while (!done && n < 20000) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      n++;
    end
    check("done_reached", done, 1);
  endtask

  initial begin
    int bc;
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Reset
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_cnt, 0);
    check("rst_first", first_err, 0);
    check("rst_tmo", tmo, 0);
    check("rst_cyc", bus.cyc, 0);
    check("rst_stb", bus.stb, 0);

    // Clean run
    clear_counts();
    pulse_start(32'hA5A5_0000);
    wait_done(bc);
    check("clean_acks", acks, 4096);
    check("clean_writes", writes, 2048);
    check("clean_w0_dat", w0_dat, 32'hA5A5_0000);
    check("clean_pass", pass, 1);
    check("clean_err", err_cnt, 0);
    check("clean_busy_cycles", (bc >= 8190 && bc <= 8194), 1);

    // Stuck-at-0 on bit 7 of word 0x155
    stuck_en = 1'b1;
    clear_counts();
    pulse_start(32'h0);
    wait_done(bc);
    check("stuck_err", err_cnt, 1);
    check("stuck_first", first_err, 10'h155);
    check("stuck_pass", pass, 0);
    stuck_en = 1'b0;

    // Start mid-W1 is ignored
    clear_counts();
    pulse_start(32'h1234_5678);
    n = 0;
    while (!(acks > 1100 && bus.stb && bus.we) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("midw1_found", (n < 20000), 1);
    pulse_start(32'hFFFF_FFFF);
    check("midw1_busy", busy, 1);
    wait_done(bc);
    check("midw1_acks", acks, 4096);
    check("midw1_writes", writes, 2048);
    check("midw1_pass", pass, 1);

    // Start in DONE restarts with the new seed
    clear_counts();
    pulse_start(32'h0F0F_0F0F);
    check("restart_done_clr", done, 0);
    check("restart_busy", busy, 1);
    wait_done(bc);
    check("restart_w0_dat", w0_dat, 32'h0F0F_0F0F);
    check("restart_pass", pass, 1);

    // Async reset during R1
    clear_counts();
    pulse_start(32'hDEAD_BEEF);
    n = 0;
    while (!(acks >= 3500 && bus.stb) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check("r1_found", (n < 20000), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cyc", bus.cyc, 0);
    check("arst_stb", bus.stb, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    pulse_start(32'h5555_AAAA);
    wait_done(bc);
    check("arst_rerun_pass", pass, 1);
    check("arst_rerun_err", err_cnt, 0);

`ifdef SRAM_WB_TESTER_TIMEOUT_EN
    // Missing ack on word 0x010
    begin
      int t0;
      int seen;
      noack_en = 1'b1;
      clear_counts();
      pulse_start(32'h0);
      n = 0;
      while (!(bus.stb && idx == 10'h010) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      t0 = n;
      while (!tmo && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check("tmo_latency", n - t0, TMO);
      check("tmo_pass", pass, 0);
      check("tmo_done", done, 1);
      seen = 0;
      repeat (20) begin
        @(negedge clk);
        if (bus.stb) seen++;
      end
      check("tmo_no_more_stb", seen, 0);
      noack_en = 1'b0;
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
